// File: rtl/acc_reg_pkg.sv
// acc_reg_pkg: shared types and constants for the accumulator register.
//   op_e    : 3-bit opcode (NOP, LOAD, CLR, INC, DEC, SHL, SHR, ROL)
//   state_e : control FSM states (IDLE, SHIFT)
//   OP_W    : opcode width
//   RST_VAL : accumulator reset value
package acc_reg_pkg;

  localparam int OP_W    = 3;
  localparam bit RST_VAL = '0;

  typedef enum logic [OP_W-1:0] {
    OP_NOP  = 3'd0,
    OP_LOAD = 3'd1,
    OP_CLR  = 3'd2,
    OP_INC  = 3'd3,
    OP_DEC  = 3'd4,
    OP_SHL  = 3'd5,
    OP_SHR  = 3'd6,
    OP_ROL  = 3'd7
  } op_e;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

endpackage

// File: rtl/acc_step.sv
// acc_step: combinational single-step datapath of the accumulator.
//   op_i    : operation to apply
//   acc_i   : current accumulator value
//   acc_o   : accumulator value after one step of op_i
//   carry_o : carry/borrow or bit shifted/rotated out by this step
// LOAD and NOP pass acc_i through with carry 0; LOAD data is muxed in by the
// caller. Shift ops move exactly one bit per call.
module acc_step
  import acc_reg_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  op_e              op_i,
  input  logic [WIDTH-1:0] acc_i,
  output logic [WIDTH-1:0] acc_o,
  output logic             carry_o
);

  always_comb begin
    acc_o   = acc_i;
    carry_o = 1'b0;
    unique case (op_i)
      OP_CLR: acc_o = '0;
      OP_INC: {carry_o, acc_o} = {1'b0, acc_i} + (WIDTH+1)'(1);
      // 0 - 1 wraps to all ones with the extra bit set, i.e. borrow.
      OP_DEC: {carry_o, acc_o} = {1'b0, acc_i} - (WIDTH+1)'(1);
      OP_SHL: begin
        carry_o = acc_i[WIDTH-1];
        acc_o   = {acc_i[WIDTH-2:0], 1'b0};
      end
      OP_SHR: begin
        carry_o = acc_i[0];
        acc_o   = {1'b0, acc_i[WIDTH-1:1]};
      end
      OP_ROL: begin
        carry_o = acc_i[WIDTH-1];
        acc_o   = {acc_i[WIDTH-2:0], acc_i[WIDTH-1]};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/acc_reg.sv
// acc_reg: parametrised accumulator register with load/clear/inc/dec and
// multi-cycle shift/rotate (one bit per clock).
//   clk, rst_n       : clock, asynchronous active-low reset
//   op_valid, op     : operation request, sampled only in IDLE
//   data_in          : LOAD operand
//   shamt            : shift/rotate amount for SHL/SHR/ROL
//   out              : accumulator value (registered)
//   busy             : multi-cycle shift in progress
//   done             : one-cycle completion pulse
//   flag_z/c/n       : zero, carry, negative flags (registered)
// Build option: define ACC_REG_FLAGS_EN to include the flag registers;
// without it the flags are tied to 0.
module acc_reg
  import acc_reg_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               op_valid,
  input  logic [OP_W-1:0]    op,
  input  logic [WIDTH-1:0]   data_in,
  input  logic [SHAMT_W-1:0] shamt,
  output logic [WIDTH-1:0]   out,
  output logic               busy,
  output logic               done,
  output logic               flag_z,
  output logic               flag_c,
  output logic               flag_n
);

  state_e               state_q, state_d;
  logic [SHAMT_W-1:0]   cnt_q, cnt_d;
  op_e                  op_q, op_d;
  logic [WIDTH-1:0]     acc_q, acc_d;
  logic                 done_q, done_d;
  logic                 wr_acc;

  op_e                  op_in, step_op;
  logic [WIDTH-1:0]     step_acc;
  logic                 step_c;

  assign op_in = op_e'(op);

  acc_step #(.WIDTH(WIDTH)) u_step (
    .op_i    (step_op),
    .acc_i   (acc_q),
    .acc_o   (step_acc),
    .carry_o (step_c)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    acc_d   = acc_q;
    done_d  = 1'b0;
    wr_acc  = 1'b0;
    step_op = op_in;
    unique case (state_q)
      IDLE: begin
        if (op_valid) begin
          done_d = 1'b1;
          unique case (op_in)
            OP_NOP: ;
            OP_LOAD: begin
              acc_d  = data_in;
              wr_acc = 1'b1;
            end
            OP_CLR, OP_INC, OP_DEC: begin
              acc_d  = step_acc;
              wr_acc = 1'b1;
            end
            default: begin
              // Shift/rotate: shamt=0 is a NOP; otherwise the first step
              // happens here and the rest run in SHIFT.
              if (shamt != '0) begin
                acc_d  = step_acc;
                wr_acc = 1'b1;
                if (shamt != SHAMT_W'(1)) begin
                  state_d = SHIFT;
                  cnt_d   = shamt - SHAMT_W'(1);
                  op_d    = op_in;
                  done_d  = 1'b0;
                end
              end
            end
          endcase
        end
      end
      SHIFT: begin
        step_op = op_q;
        acc_d   = step_acc;
        wr_acc  = 1'b1;
        cnt_d   = cnt_q - SHAMT_W'(1);
        if (cnt_q == SHAMT_W'(1)) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= OP_NOP;
      acc_q   <= WIDTH'(RST_VAL);
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      acc_q   <= acc_d;
      done_q  <= done_d;
    end
  end

  assign out  = acc_q;
  assign busy = (state_q == SHIFT);
  assign done = done_q;

`ifdef ACC_REG_FLAGS_EN
  logic z_q, c_q, n_q;

  // Flags follow every accumulator write; LOAD/CLR get carry 0 from the step.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      z_q <= 1'b1;
      c_q <= 1'b0;
      n_q <= 1'b0;
    end else if (wr_acc) begin
      z_q <= (acc_d == '0);
      c_q <= step_c;
      n_q <= acc_d[WIDTH-1];
    end
  end

  assign flag_z = z_q;
  assign flag_c = c_q;
  assign flag_n = n_q;
`else
  logic unused_flags;
  assign unused_flags = ^{step_c, wr_acc};
  assign flag_z = 1'b0;
  assign flag_c = 1'b0;
  assign flag_n = 1'b0;
`endif

endmodule

// File: tb/tb_acc_reg.sv
module tb_acc_reg;
  import acc_reg_pkg::*;

`ifdef ACC_REG_FLAGS_EN
  localparam bit FEN = 1'b1;
`else
  localparam bit FEN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       op_valid = 1'b0;
  logic [2:0] op = 3'd0;
  logic [7:0] data_in = 8'd0;
  logic [2:0] shamt = 3'd0;
  logic [7:0] out;
  logic       busy, done, flag_z, flag_c, flag_n;

  acc_reg #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .op_valid(op_valid), .op(op),
    .data_in(data_in), .shamt(shamt), .out(out), .busy(busy), .done(done),
    .flag_z(flag_z), .flag_c(flag_c), .flag_n(flag_n)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      nm;
    logic [7:0] acc;
    logic [2:0] zcn;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Expected completion: flags collapse to 0 when the flag build is off.
  task automatic push(input string nm, input logic [7:0] a, input bit z, input bit c, input bit n);
    exp_t e;
    e.nm  = nm;
    e.acc = a;
    e.zcn = FEN ? {z, c, n} : 3'b000;
    sb.push_back(e);
  endtask

  // Monitor: every done pulse consumes one expected completion.
  always @(negedge clk) begin
    if (done) begin
      if (sb.size() == 0) begin
        chk("spurious_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk({e.nm, "_out"}, 32'(out), 32'(e.acc));
        chk({e.nm, "_zcn"}, 32'({flag_z, flag_c, flag_n}), 32'(e.zcn));
      end
    end
  end

  // Drive a request, hold it across one rising edge, then drop op_valid.
  task automatic issue(input logic [2:0] o, input logic [7:0] d, input logic [2:0] k);
    op_valid = 1'b1;
    op       = o;
    data_in  = d;
    shamt    = k;
    @(posedge clk);
    #1;
    op_valid = 1'b0;
  endtask

  // Count busy cycles after acceptance, bounded.
  task automatic wait_idle(input string nm, input int exp_busy);
    int n = 0;
    @(negedge clk);
    while (busy && n < 40) begin
      n++;
      @(negedge clk);
    end
    chk({nm, "_busy_cycles"}, 32'(n), 32'(exp_busy));
  endtask

  initial begin
    // Reset state
    @(negedge clk);
    @(negedge clk);
    chk("rst_out", 32'(out), 32'h0);
    chk("rst_busy_done", 32'({busy, done}), 32'h0);
    chk("rst_zcn", 32'({flag_z, flag_c, flag_n}), FEN ? 32'b100 : 32'b000);
    rst_n = 1'b1;
    @(negedge clk);

    // Reset then LOAD 0x80
    push("load80", 8'h80, 0, 0, 1);
    issue(OP_LOAD, 8'h80, 3'd0);
    wait_idle("load80", 0);

    // INC wrap then DEC borrow
    push("loadff", 8'hFF, 0, 0, 1);
    issue(OP_LOAD, 8'hFF, 3'd0);
    push("inc_wrap", 8'h00, 1, 1, 0);
    issue(OP_INC, 8'h00, 3'd0);
    push("dec_borrow", 8'hFF, 0, 1, 1);
    issue(OP_DEC, 8'h00, 3'd0);
    // NOP and shamt=0 shift keep acc and flags
    push("nop", 8'hFF, 0, 1, 1);
    issue(OP_NOP, 8'h12, 3'd0);
    push("shl0", 8'hFF, 0, 1, 1);
    issue(OP_SHL, 8'h00, 3'd0);
    // Back-to-back single-cycle ops
    push("b2b_load", 8'h05, 0, 0, 0);
    issue(OP_LOAD, 8'h05, 3'd0);
    push("b2b_inc1", 8'h06, 0, 0, 0);
    issue(OP_INC, 8'h00, 3'd0);
    push("b2b_inc2", 8'h07, 0, 0, 0);
    issue(OP_INC, 8'h00, 3'd0);
    push("b2b_clr", 8'h00, 1, 0, 0);
    issue(OP_CLR, 8'h00, 3'd0);
    wait_idle("b2b", 0);

    // Multi-cycle SHL with visible intermediate values
    push("load81a", 8'h81, 0, 0, 1);
    issue(OP_LOAD, 8'h81, 3'd0);
    push("shl3", 8'h08, 0, 0, 0);
    issue(OP_SHL, 8'h00, 3'd3);
    @(negedge clk);
    chk("shl3_step1", 32'({busy, out}), 32'h102);
    @(negedge clk);
    chk("shl3_step2", 32'({busy, out}), 32'h104);
    @(negedge clk);
    chk("shl3_step3", 32'({busy, done, out}), 32'h108);

    // ROL, then ROL 4 with a CLR request held during busy
    push("load81b", 8'h81, 0, 0, 1);
    issue(OP_LOAD, 8'h81, 3'd0);
    push("rol1", 8'h03, 0, 1, 0);
    issue(OP_ROL, 8'h00, 3'd1);
    push("rol4", 8'h30, 0, 0, 0);
    issue(OP_ROL, 8'h00, 3'd4);
    op_valid = 1'b1;
    op       = OP_CLR;
    begin
      int n = 0;
      @(negedge clk);
      while (busy && n < 40) begin
        n++;
        @(negedge clk);
      end
      op_valid = 1'b0;
      chk("rol4_busy_cycles", 32'(n), 32'd3);
    end

    // Long shifts toward saturation
    push("loadff2", 8'hFF, 0, 0, 1);
    issue(OP_LOAD, 8'hFF, 3'd0);
    push("shl7", 8'h80, 0, 1, 1);
    issue(OP_SHL, 8'h00, 3'd7);
    wait_idle("shl7", 6);
    push("load01", 8'h01, 0, 0, 0);
    issue(OP_LOAD, 8'h01, 3'd0);
    push("shr1", 8'h00, 1, 1, 0);
    issue(OP_SHR, 8'h00, 3'd1);
    wait_idle("shr1", 0);

    // Reset mid-shift: no done, then normal operation resumes
    push("loadf0", 8'hF0, 0, 0, 1);
    issue(OP_LOAD, 8'hF0, 3'd0);
    issue(OP_SHR, 8'h00, 3'd5);
    @(negedge clk);
    chk("shr5_step1", 32'({busy, out}), 32'h178);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_out", 32'(out), 32'h0);
    chk("abort_busy_done", 32'({busy, done}), 32'h0);
    chk("abort_zcn", 32'({flag_z, flag_c, flag_n}), FEN ? 32'b100 : 32'b000);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    push("after_rst", 8'h3C, 0, 0, 0);
    issue(OP_LOAD, 8'h3C, 3'd0);
    wait_idle("after_rst", 0);

    // Drain the scoreboard
    begin
      int n = 0;
      while (sb.size() != 0 && n < 20) begin
        n++;
        @(negedge clk);
      end
      chk("sb_drained", 32'(sb.size()), 32'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
